mips_test_sequencer: RTL and testbench
======================================

Name: mips_test_sequencer

Overview:
- Parametrised run-and-check controller for CPU-level tests.
- Generates the CPU reset pulse and lets the core run for a bounded number of cycles, or stops early on a halt indication.
- Then freezes the core and scans its register file through a debug read port.
- Compares each register against an expected value and accumulates a signature, reporting pass/fail, error count and first failing index.
- Sits between the bench top and the mips core.

Parameters:
- DATA_W, 32, register width
- NREGS, 32, number of registers scanned
- ADDR_W, 5, debug address width (2**ADDR_W >= NREGS)
- RST_CYCLES, 2, cycles cpu_reset is held high
- RUN_CYCLES, 300, maximum run cycles (>= 1)
- CNT_W, 32, cycle counter width
- RD_LAT, 0, debug read latency in cycles (0 = combinational read)
- HALT_EN, 1, 1 = halt input ends the run early

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- start  in  1  single-cycle start request
- halt  in  1  core halted indication
- cpu_reset  out  1  reset to core
- cpu_hold  out  1  core clock-enable inhibit (1 = frozen)
- dbg_rd_en  out  1  debug read strobe
- dbg_addr  out  ADDR_W  debug register index
- dbg_rdata  in  DATA_W  register data, valid RD_LAT cycles after strobe
- exp_data  in  DATA_W  expected value, aligned with dbg_rdata
- busy  out  1  sequence in progress
- done  out  1  sequence complete
- pass  out  1  done and zero mismatches
- halted  out  1  run ended by halt (0 = ended by timeout)
- err_count  out  ADDR_W+1  mismatch count
- first_err  out  ADDR_W  index of first mismatch
- signature  out  DATA_W  register-file signature
- cycle_count  out  CNT_W  run cycles executed

Behaviour:
- Clock is clk; reset is synchronous, active-high.
- Reset values: state IDLE, cpu_reset=0, cpu_hold=1, dbg_rd_en=0, dbg_addr=0, busy=0, done=0, pass=0, halted=0, err_count=0, first_err=0, signature=0, cycle_count=0.
- State IDLE:
  - start -> RST.
  - All statistics are cleared on that transition.
- State RST:
  - cpu_reset=1 and cpu_hold=0 for exactly RST_CYCLES cycles, then RUN.
  - busy=1 from RST through SCAN.
- State RUN:
  - cpu_reset=0, cpu_hold=0.
  - cycle_count increments every RUN cycle.
  - Leave RUN after the cycle where cycle_count reaches RUN_CYCLES, or the cycle after halt is sampled high (only when HALT_EN=1).
  - halted=1 if halt caused the exit; on the same cycle, halt wins.
  - cpu_hold=1 from the following cycle.
- State SCAN:
  - One read per cycle: dbg_rd_en=1, dbg_addr=0..NREGS-1, then dbg_rd_en=0.
  - A valid shift pipe of depth RD_LAT tags returning data.
  - On each valid return: signature <= rotl1(signature) ^ dbg_rdata.
  - On dbg_rdata != exp_data, err_count increments (saturating at all ones); first_err is latched on the first mismatch only.
  - Exit SCAN after the last return has been processed. SCAN lasts NREGS+RD_LAT cycles.
- State DONE:
  - done=1, busy=0, pass=(err_count==0). All results are held.
  - start -> RST and clears results; this is a restart.
- start is ignored in RST, RUN and SCAN.
- halt is ignored outside RUN.
- Reset mid-sequence returns to IDLE next cycle, with all outputs at reset values.
- A halt sampled on the first RUN cycle is honoured: cycle_count=1.

Decomposition:
- Shared package mips_test_pkg:
  - state encoding (IDLE, RST, RUN, SCAN, DONE)
  - rotl1 signature function
  - default parameter constants
- One sub-module: mips_scan_checker, covering the read pipe, compare, error count, first_err and signature. It gets start_scan and last_done handshakes from the FSM.

Test Plan:
- Reset, then start with RST_CYCLES=2, RUN_CYCLES=300, halt=0:
  - cpu_reset high exactly 2 cycles.
  - cpu_hold falls for 302 cycles.
  - cycle_count=300, halted=0.
- halt asserted on RUN cycle 50 -> cycle_count=50, halted=1, SCAN begins the next cycle.
- NREGS=4, RD_LAT=0, data 1,2,3,4 equal to exp_data -> signature=0x00000002, err_count=0, pass=1, done=1.
- Same configuration with exp_data at index 1 = 0xFF and index 3 = 0x0 -> err_count=2, first_err=1, pass=0.
- RD_LAT=2, NREGS=32 -> SCAN lasts 34 cycles, all 32 compares are aligned, and done rises on the cycle after the last return.
- reset asserted mid-SCAN, then start pulses during RUN -> IDLE with all outputs zero and cpu_hold=1, and the extra start pulses are ignored; start from DONE restarts and clears err_count.

Source files
------------

// File: rtl/mips_test_pkg.sv
// Shared definitions for the CPU run-and-check sequencer: state encoding,
// default configuration and the signature rotate helper.
package mips_test_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RST,
    ST_RUN,
    ST_SCAN,
    ST_DONE
  } state_t;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_NREGS      = 32;
  localparam int DEF_ADDR_W     = 5;
  localparam int DEF_RST_CYCLES = 2;
  localparam int DEF_RUN_CYCLES = 300;
  localparam int DEF_CNT_W      = 32;
  localparam int DEF_RD_LAT     = 0;
  localparam int DEF_HALT_EN    = 1;

  // Widest signature the rotate helper supports; callers zero-extend into it.
  localparam int SIG_MAX_W = 64;

  // Rotate the low w bits of v left by one; bits at and above w return zero.
  function automatic logic [SIG_MAX_W-1:0] rotl1(input logic [SIG_MAX_W-1:0] v,
                                                 input int w);
    logic [SIG_MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < SIG_MAX_W; i++) begin
      if (i == w - 1) r[0] = v[i];
    end
    for (int i = 1; i < SIG_MAX_W; i++) begin
      if (i < w) r[i] = v[i-1];
    end
    return r;
  endfunction

endpackage

// File: rtl/mips_scan_checker.sv
// Register-file scan engine: issues one debug read per cycle, tags returning
// data through a latency pipe, and accumulates errors and a signature.
module mips_scan_checker
  import mips_test_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NREGS  = DEF_NREGS,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int RD_LAT = DEF_RD_LAT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              start_scan,
  output logic              dbg_rd_en,
  output logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_rdata,
  input  logic [DATA_W-1:0] exp_data,
  output logic              last_done,
  output logic [ADDR_W:0]   err_count,
  output logic [ADDR_W-1:0] first_err,
  output logic [DATA_W-1:0] signature
);

  logic              issuing_reg;
  logic [ADDR_W-1:0] issue_idx_reg;
  logic [ADDR_W-1:0] ret_idx_reg;
  logic [ADDR_W:0]   err_count_reg;
  logic [ADDR_W-1:0] first_err_reg;
  logic [DATA_W-1:0] signature_reg;
  logic [DATA_W-1:0] sig_rot;
  logic              ret_valid;
  logic              mismatch;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      issuing_reg   <= 1'b0;
      issue_idx_reg <= '0;
    end else if (start_scan) begin
      issuing_reg   <= 1'b1;
      issue_idx_reg <= '0;
    end else if (issuing_reg) begin
      if (issue_idx_reg == ADDR_W'(NREGS - 1)) begin
        issuing_reg   <= 1'b0;
        issue_idx_reg <= '0;
      end else begin
        issue_idx_reg <= issue_idx_reg + 1'b1;
      end
    end
  end

  assign dbg_rd_en = issuing_reg;
  assign dbg_addr  = issue_idx_reg;

  // The strobe is delayed by RD_LAT stages so it lines up with dbg_rdata.
  generate
    if (RD_LAT == 0) begin : g_comb
      assign ret_valid = issuing_reg;
    end else begin : g_pipe
      logic [RD_LAT:0] vchain;
      assign vchain[0] = issuing_reg;
      for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_stage
        logic v_reg;
        always_ff @(posedge clk) begin
          if (reset || clear) v_reg <= 1'b0;
          else                v_reg <= vchain[gi];
        end
        assign vchain[gi+1] = v_reg;
      end
      assign ret_valid = vchain[RD_LAT];
    end
  endgenerate

  assign sig_rot  = DATA_W'(rotl1(SIG_MAX_W'(signature_reg), DATA_W));
  assign mismatch = (dbg_rdata != exp_data);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      ret_idx_reg   <= '0;
      err_count_reg <= '0;
      first_err_reg <= '0;
      signature_reg <= '0;
    end else if (ret_valid) begin
      signature_reg <= sig_rot ^ dbg_rdata;
      if (mismatch) begin
        // A zero count means no earlier mismatch, since the count saturates.
        if (err_count_reg == '0) first_err_reg <= ret_idx_reg;
        if (err_count_reg != '1) err_count_reg <= err_count_reg + 1'b1;
      end
      if (ret_idx_reg == ADDR_W'(NREGS - 1)) ret_idx_reg <= '0;
      else                                   ret_idx_reg <= ret_idx_reg + 1'b1;
    end
  end

  assign last_done = ret_valid && (ret_idx_reg == ADDR_W'(NREGS - 1));
  assign err_count = err_count_reg;
  assign first_err = first_err_reg;
  assign signature = signature_reg;

endmodule

// File: rtl/mips_test_sequencer.sv
// Run-and-check controller: resets the core, runs it for a bounded number of
// cycles or until halt, then freezes it and scans the register file.
module mips_test_sequencer
  import mips_test_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int NREGS      = DEF_NREGS,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int RST_CYCLES = DEF_RST_CYCLES,
  parameter int RUN_CYCLES = DEF_RUN_CYCLES,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int RD_LAT     = DEF_RD_LAT,
  parameter int HALT_EN    = DEF_HALT_EN
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              halt,
  output logic              cpu_reset,
  output logic              cpu_hold,
  output logic              dbg_rd_en,
  output logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_rdata,
  input  logic [DATA_W-1:0] exp_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              halted,
  output logic [ADDR_W:0]   err_count,
  output logic [ADDR_W-1:0] first_err,
  output logic [DATA_W-1:0] signature,
  output logic [CNT_W-1:0]  cycle_count
);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] rst_cnt_reg, rst_cnt_next;
  logic [CNT_W-1:0] cycle_count_reg, cycle_count_next;
  logic             halted_reg, halted_next;
  logic             clear;
  logic             start_scan;
  logic             last_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      rst_cnt_reg     <= '0;
      cycle_count_reg <= '0;
      halted_reg      <= 1'b0;
    end else begin
      state_reg       <= state_next;
      rst_cnt_reg     <= rst_cnt_next;
      cycle_count_reg <= cycle_count_next;
      halted_reg      <= halted_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    rst_cnt_next     = rst_cnt_reg;
    cycle_count_next = cycle_count_reg;
    halted_next      = halted_reg;
    clear            = 1'b0;
    start_scan       = 1'b0;
    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_next       = ST_RST;
          clear            = 1'b1;
          rst_cnt_next     = '0;
          cycle_count_next = '0;
          halted_next      = 1'b0;
        end
      end
      ST_RST: begin
        if (rst_cnt_reg == CNT_W'(RST_CYCLES - 1)) begin
          state_next   = ST_RUN;
          rst_cnt_next = '0;
        end else begin
          rst_cnt_next = rst_cnt_reg + 1'b1;
        end
      end
      ST_RUN: begin
        cycle_count_next = cycle_count_reg + 1'b1;
        // Halt takes priority so a halt on the final cycle still reports halted.
        if ((HALT_EN != 0) && halt) begin
          halted_next = 1'b1;
          state_next  = ST_SCAN;
          start_scan  = 1'b1;
        end else if (cycle_count_next == CNT_W'(RUN_CYCLES)) begin
          state_next = ST_SCAN;
          start_scan = 1'b1;
        end
      end
      ST_SCAN: begin
        if (last_done) state_next = ST_DONE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  mips_scan_checker #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS),
    .ADDR_W (ADDR_W),
    .RD_LAT (RD_LAT)
  ) u_checker (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .start_scan (start_scan),
    .dbg_rd_en  (dbg_rd_en),
    .dbg_addr   (dbg_addr),
    .dbg_rdata  (dbg_rdata),
    .exp_data   (exp_data),
    .last_done  (last_done),
    .err_count  (err_count),
    .first_err  (first_err),
    .signature  (signature)
  );

  assign cpu_reset   = (state_reg == ST_RST);
  assign cpu_hold    = !((state_reg == ST_RST) || (state_reg == ST_RUN));
  assign busy        = (state_reg == ST_RST) || (state_reg == ST_RUN) ||
                       (state_reg == ST_SCAN);
  assign done        = (state_reg == ST_DONE);
  assign pass        = done && (err_count == '0);
  assign halted      = halted_reg;
  assign cycle_count = cycle_count_reg;

endmodule

// File: tb/tb_mips_test_sequencer.sv
// Scoreboard bench: two sequencer instances (4 regs / comb read, 32 regs /
// 2-cycle read) share start/halt/reset and are checked against a result model.
module tb_mips_test_sequencer;

  localparam int RSTC = 2;
  localparam int RUNC = 300;

  typedef struct {
    logic [31:0] sig;
    logic [5:0]  errc;
    logic [4:0]  ferr;
    logic        halted;
    logic [31:0] cyc;
    logic        pass;
    int          nrst;
    int          nrun;
    int          nscan;
  } res_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic halt = 1'b0;

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  res_t q_a[$];
  res_t q_b[$];

  logic [31:0] rf_a [32];
  logic [31:0] ex_a [32];
  logic [31:0] rf_b [32];
  logic [31:0] ex_b [32];

  logic        cpu_reset_a, cpu_hold_a, dbg_rd_en_a, busy_a, done_a, pass_a, halted_a;
  logic [4:0]  dbg_addr_a, first_err_a;
  logic [5:0]  err_count_a;
  logic [31:0] dbg_rdata_a, exp_data_a, signature_a, cycle_count_a;

  logic        cpu_reset_b, cpu_hold_b, dbg_rd_en_b, busy_b, done_b, pass_b, halted_b;
  logic [4:0]  dbg_addr_b, first_err_b;
  logic [5:0]  err_count_b;
  logic [31:0] dbg_rdata_b, exp_data_b, signature_b, cycle_count_b;
  logic [31:0] d1_b, d2_b, e1_b, e2_b;

  assign dbg_rdata_a = rf_a[dbg_addr_a];
  assign exp_data_a  = ex_a[dbg_addr_a];

  // Two-cycle registered read port model for instance b.
  always @(posedge clk) begin
    d1_b <= rf_b[dbg_addr_b];
    e1_b <= ex_b[dbg_addr_b];
    d2_b <= d1_b;
    e2_b <= e1_b;
  end
  assign dbg_rdata_b = d2_b;
  assign exp_data_b  = e2_b;

  mips_test_sequencer #(
    .DATA_W(32), .NREGS(4), .ADDR_W(5), .RST_CYCLES(RSTC), .RUN_CYCLES(RUNC),
    .CNT_W(32), .RD_LAT(0), .HALT_EN(1)
  ) dut_a (
    .clk(clk), .reset(reset), .start(start), .halt(halt),
    .cpu_reset(cpu_reset_a), .cpu_hold(cpu_hold_a), .dbg_rd_en(dbg_rd_en_a),
    .dbg_addr(dbg_addr_a), .dbg_rdata(dbg_rdata_a), .exp_data(exp_data_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .halted(halted_a),
    .err_count(err_count_a), .first_err(first_err_a), .signature(signature_a),
    .cycle_count(cycle_count_a)
  );

  mips_test_sequencer #(
    .DATA_W(32), .NREGS(32), .ADDR_W(5), .RST_CYCLES(RSTC), .RUN_CYCLES(RUNC),
    .CNT_W(32), .RD_LAT(2), .HALT_EN(1)
  ) dut_b (
    .clk(clk), .reset(reset), .start(start), .halt(halt),
    .cpu_reset(cpu_reset_b), .cpu_hold(cpu_hold_b), .dbg_rd_en(dbg_rd_en_b),
    .dbg_addr(dbg_addr_b), .dbg_rdata(dbg_rdata_b), .exp_data(exp_data_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .halted(halted_b),
    .err_count(err_count_b), .first_err(first_err_b), .signature(signature_b),
    .cycle_count(cycle_count_b)
  );

  // Expected outcome of one full sequence, derived from the register contents.
  function automatic res_t model(input logic [31:0] rf [32], input logic [31:0] ex [32],
                                 input int n, input int lat, input int halt_at);
    res_t r;
    r.sig  = 32'h0;
    r.errc = 6'd0;
    r.ferr = 5'd0;
    for (int i = 0; i < n; i++) begin
      r.sig = {r.sig[30:0], r.sig[31]} ^ rf[i];
      if (rf[i] != ex[i]) begin
        if (r.errc == 6'd0) r.ferr = 5'(i);
        r.errc = r.errc + 6'd1;
      end
    end
    if (halt_at > 0 && halt_at <= RUNC) begin
      r.halted = 1'b1;
      r.cyc    = 32'(halt_at);
    end else begin
      r.halted = 1'b0;
      r.cyc    = 32'(RUNC);
    end
    r.pass  = (r.errc == 6'd0);
    r.nrst  = RSTC;
    r.nrun  = RSTC + int'(r.cyc);
    r.nscan = n + lat;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic check_res(input string tag, input res_t act, input res_t req);
    chk({tag, ".signature"}, 64'(act.sig), 64'(req.sig));
    chk({tag, ".err_count"}, 64'(act.errc), 64'(req.errc));
    chk({tag, ".first_err"}, 64'(act.ferr), 64'(req.ferr));
    chk({tag, ".halted"}, 64'(act.halted), 64'(req.halted));
    chk({tag, ".cycle_count"}, 64'(act.cyc), 64'(req.cyc));
    chk({tag, ".pass"}, 64'(act.pass), 64'(req.pass));
    chk({tag, ".rst_cycles"}, 64'(act.nrst), 64'(req.nrst));
    chk({tag, ".hold_low_cycles"}, 64'(act.nrun), 64'(req.nrun));
    chk({tag, ".scan_cycles"}, 64'(act.nscan), 64'(req.nscan));
    $display("[TB] %s done: sig=0x%08h errc=%0d ferr=%0d halted=%0d cyc=%0d",
             tag, act.sig, act.errc, act.ferr, act.halted, act.cyc);
  endtask

  // Monitors: count phase lengths and compare the result when done rises.
  int  nrst_a, nrun_a, nscan_a, nrst_b, nrun_b, nscan_b;
  logic pdone_a = 1'b0, pdone_b = 1'b0;

  always @(negedge clk) begin
    res_t act, req;
    if (reset) begin
      nrst_a = 0; nrun_a = 0; nscan_a = 0;
    end else begin
      if (cpu_reset_a) nrst_a++;
      if (!cpu_hold_a) nrun_a++;
      if (busy_a && cpu_hold_a) nscan_a++;
      if (done_a && !pdone_a) begin
        act = '{signature_a, err_count_a, first_err_a, halted_a, cycle_count_a,
                pass_a, nrst_a, nrun_a, nscan_a};
        tests++;
        if (q_a.size() == 0) begin
          fails++;
          $display("FAIL a.unexpected_done: got done with 0 queued, expected queued result");
        end else begin
          req = q_a.pop_front();
          check_res("a", act, req);
        end
        nrst_a = 0; nrun_a = 0; nscan_a = 0;
      end
    end
    pdone_a = done_a;
  end

  always @(negedge clk) begin
    res_t act, req;
    if (reset) begin
      nrst_b = 0; nrun_b = 0; nscan_b = 0;
    end else begin
      if (cpu_reset_b) nrst_b++;
      if (!cpu_hold_b) nrun_b++;
      if (busy_b && cpu_hold_b) nscan_b++;
      if (done_b && !pdone_b) begin
        act = '{signature_b, err_count_b, first_err_b, halted_b, cycle_count_b,
                pass_b, nrst_b, nrun_b, nscan_b};
        tests++;
        if (q_b.size() == 0) begin
          fails++;
          $display("FAIL b.unexpected_done: got done with 0 queued, expected queued result");
        end else begin
          req = q_b.pop_front();
          check_res("b", act, req);
        end
        nrst_b = 0; nrun_b = 0; nscan_b = 0;
      end
    end
    pdone_b = done_b;
  end

  task automatic check_reset_state(input string tag);
    logic [86:0] req, act;
    req = 87'(1) << 85;
    act = {cpu_reset_a, cpu_hold_a, dbg_rd_en_a, dbg_addr_a, busy_a, done_a, pass_a,
           halted_a, err_count_a, first_err_a, signature_a, cycle_count_a};
    chk({tag, ".a_outputs"}, act[63:0], req[63:0]);
    chk({tag, ".a_outputs_hi"}, 64'(act[86:64]), 64'(req[86:64]));
    act = {cpu_reset_b, cpu_hold_b, dbg_rd_en_b, dbg_addr_b, busy_b, done_b, pass_b,
           halted_b, err_count_b, first_err_b, signature_b, cycle_count_b};
    chk({tag, ".b_outputs"}, act[63:0], req[63:0]);
    chk({tag, ".b_outputs_hi"}, 64'(act[86:64]), 64'(req[86:64]));
  endtask

  task automatic fill_random_b();
    for (int i = 0; i < 32; i++) begin
      rf_b[i] = $urandom;
      ex_b[i] = ($urandom_range(0, 5) == 0) ? (rf_b[i] ^ (32'h1 << $urandom_range(0, 31)))
                                            : rf_b[i];
    end
  endtask

  task automatic fill_random_a(input bit clean);
    for (int i = 0; i < 32; i++) begin
      rf_a[i] = $urandom;
      ex_a[i] = (!clean && $urandom_range(0, 2) == 0) ? ~rf_a[i] : rf_a[i];
    end
  endtask

  // Called #1 after a rising edge. abort: reset the DUTs mid-SCAN instead of finishing.
  task automatic run_seq(input string tag, input int halt_at, input bit extra_start,
                         input bit abort);
    int w;
    if (!abort) begin
      q_a.push_back(model(rf_a, ex_a, 4, 0, halt_at));
      q_b.push_back(model(rf_b, ex_b, 32, 2, halt_at));
    end
    $display("[TB] %s: start halt_at=%0d extra_start=%0d abort=%0d",
             tag, halt_at, extra_start, abort);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, ".err_cleared_on_start"}, 64'(err_count_a), 64'd0);
    repeat (RSTC) @(posedge clk);
    #1;
    if (extra_start) begin
      repeat (3) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (2) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    if (halt_at > 0) begin
      repeat (halt_at - 1) @(posedge clk);
      #1 halt = 1'b1;
      @(posedge clk); #1 halt = 1'b0;
    end
    if (abort) begin
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      #1 check_reset_state({tag, ".after_abort"});
      repeat (3) @(posedge clk);
      #1 check_reset_state({tag, ".idle_hold"});
      return;
    end
    w = 0;
    while (!(done_a && done_b) && w < 2000) begin
      @(posedge clk); #1;
      w++;
    end
    tests++;
    if (w >= 2000) begin
      fails++;
      $display("FAIL %s.done_timeout: got done_a=%0d done_b=%0d, expected both 1",
               tag, done_a, done_b);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1 check_reset_state("reset");
    @(posedge clk); #1;

    for (int i = 0; i < 32; i++) begin
      rf_a[i] = 32'(i + 1);
      ex_a[i] = 32'(i + 1);
    end
    fill_random_b();
    run_seq("full_run", 0, 1'b0, 1'b0);
    chk("full_run.sig_const", 64'(signature_a), 64'h2);
    chk("full_run.pass_const", 64'(pass_a), 64'd1);

    ex_a[1] = 32'hFF;
    ex_a[3] = 32'h0;
    fill_random_b();
    run_seq("halt50_errs", 50, 1'b0, 1'b0);
    chk("halt50_errs.errc_const", 64'(err_count_a), 64'd2);
    chk("halt50_errs.ferr_const", 64'(first_err_a), 64'd1);

    fill_random_a(1'b1);
    fill_random_b();
    run_seq("restart_halt1", 1, 1'b0, 1'b0);

    fill_random_a(1'b0);
    fill_random_b();
    run_seq("abort_scan", 10, 1'b0, 1'b1);

    fill_random_a(1'b0);
    fill_random_b();
    run_seq("extra_starts", 0, 1'b1, 1'b0);

    fill_random_a(1'b0);
    fill_random_b();
    run_seq("halt_tie", RUNC, 1'b0, 1'b0);

    for (int k = 0; k < 6; k++) begin
      fill_random_a($urandom_range(0, 1) == 1);
      fill_random_b();
      run_seq($sformatf("rand%0d", k), int'($urandom_range(0, RUNC + 5)), 1'b0, 1'b0);
    end

    tests++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      fails++;
      $display("FAIL queue_drain: got %0d/%0d pending, expected 0/0", q_a.size(), q_b.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
